// File: rtl/store_buffer_pkg.sv
// -----------------------------------------------------------------------------
// store_buffer_pkg
// Shared types and constants for the store buffer:
//   WORD_BYTES  - bytes per memory word
//   WADDR_W     - width of a stored word address (byte address bits [31:2])
//   sb_state_t  - drain FSM state (IDLE / WRITE)
//   sb_entry_t  - one buffered store: word address plus four data bytes,
//                 byte 0 being the lowest-addressed byte
// -----------------------------------------------------------------------------
package store_buffer_pkg;

  localparam int WORD_BYTES = 4;
  localparam int WADDR_W    = 30;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } sb_state_t;

  typedef struct packed {
    logic [WADDR_W-1:0]             waddr;
    logic [0:WORD_BYTES-1][7:0]     data;
  } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// -----------------------------------------------------------------------------
// sb_match
// Combinational DEPTH-way word-address compare against the buffered entries.
// Ports:
//   entry_waddr   - word address of every slot
//   entry_valid   - slot holds a pending store
//   head_ptr      - slot index of the FIFO head
//   head_draining - head is currently being written to memory
//   lookup_waddr  - word address being searched for
//   nd_hit        - one-hot match among non-draining entries
//   head_hit      - match on the head while it is draining
// The buffer keeps at most one non-draining entry per word address, so
// nd_hit has at most one bit set.
// -----------------------------------------------------------------------------
module sb_match
  import store_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][WADDR_W-1:0] entry_waddr,
  input  logic [DEPTH-1:0]              entry_valid,
  input  logic [PW-1:0]                 head_ptr,
  input  logic                          head_draining,
  input  logic [WADDR_W-1:0]            lookup_waddr,
  output logic [DEPTH-1:0]              nd_hit,
  output logic                          head_hit
);

  // Compare every live slot; a draining head is reported separately.
  always_comb begin
    nd_hit   = {DEPTH{1'b0}};
    head_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_waddr[i] == lookup_waddr)) begin
        if (head_draining && (PW'(i) == head_ptr)) begin
          head_hit = 1'b1;
        end else begin
          nd_hit[i] = 1'b1;
        end
      end else begin
        nd_hit[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
// Write-posting buffer between the core MEM stage and data memory. Full-word
// stores are accepted in one cycle, coalesced with pending stores to the same
// word where possible, and drained in FIFO order with mem_write_en held for
// WRITE_LAT cycles per entry. Loads are forwarded combinationally from pending
// entries.
// Ports:
//   clk, rst_b        - clock, synchronous active-high reset
//   st_valid/st_ready - store handshake; st_addr/st_data carry the store
//   ld_valid/ld_addr  - load lookup; ld_hit/ld_data give the forwarded word
//   mem_addr, mem_data_in, mem_write_en - memory write port (head entry)
//   empty, full       - occupancy flags
// -----------------------------------------------------------------------------
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int WRITE_LAT = 3
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [7:0]  st_data [0:3],
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic [7:0]  ld_data [0:3],
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_data_in [0:3],
  output logic        mem_write_en,
  output logic        empty,
  output logic        full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = (WRITE_LAT > 1) ? $clog2(WRITE_LAT) : 1;

  sb_state_t      state_q, state_d;
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic [LW-1:0]  lat_cnt_q, lat_cnt_d;
  sb_entry_t      entries_q [DEPTH];
  sb_entry_t      entries_d [DEPTH];

  logic [DEPTH-1:0][WADDR_W-1:0] entry_waddr;
  logic [DEPTH-1:0]              entry_valid;
  logic [WADDR_W-1:0]            st_waddr;
  logic [WADDR_W-1:0]            ld_waddr;
  logic [0:WORD_BYTES-1][7:0]    st_word;
  logic [0:WORD_BYTES-1][7:0]    fwd_word;
  logic [DEPTH-1:0]              st_nd_hit;
  logic [DEPTH-1:0]              ld_nd_hit;
  logic                          st_head_hit;
  logic                          ld_head_hit;
  logic                          draining;
  logic                          st_accept;
  logic                          coalesce;
  logic                          push;
  logic                          pop;
  logic [PW-1:0]                 coalesce_idx;
  logic                          lint_unused;

  // Byte offsets within a word and the store head-match play no part here.
  assign lint_unused = ^{st_addr[1:0], ld_addr[1:0], st_head_hit};

  assign draining = (state_q == WRITE);

  // Word-address extraction and byte-lane repack of the incoming store.
  always_comb begin
    st_waddr = st_addr[31:2];
    ld_waddr = ld_addr[31:2];
    for (int b = 0; b < WORD_BYTES; b++) begin
      st_word[b] = st_data[b];
    end
  end

  // A slot is live when its distance from head (mod DEPTH) is below count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_waddr[i] = entries_q[i].waddr;
      entry_valid[i] = ({1'b0, PW'(i) - head_q} < count_q);
    end
  end

  sb_match #(
    .DEPTH (DEPTH)
  ) u_st_match (
    .entry_waddr   (entry_waddr),
    .entry_valid   (entry_valid),
    .head_ptr      (head_q),
    .head_draining (draining),
    .lookup_waddr  (st_waddr),
    .nd_hit        (st_nd_hit),
    .head_hit      (st_head_hit)
  );

  sb_match #(
    .DEPTH (DEPTH)
  ) u_ld_match (
    .entry_waddr   (entry_waddr),
    .entry_valid   (entry_valid),
    .head_ptr      (head_q),
    .head_draining (draining),
    .lookup_waddr  (ld_waddr),
    .nd_hit        (ld_nd_hit),
    .head_hit      (ld_head_hit)
  );

  // Push/pop decisions. A store hitting only the in-flight head allocates a
  // new slot because st_nd_hit never includes a draining head.
  always_comb begin
    st_accept    = st_valid && st_ready;
    coalesce     = st_accept && (|st_nd_hit);
    push         = st_accept && !coalesce;
    pop          = draining && (lat_cnt_q == LW'(WRITE_LAT - 1));
    coalesce_idx = {PW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (st_nd_hit[i]) begin
        coalesce_idx = PW'(i);
      end else begin
        coalesce_idx = coalesce_idx;
      end
    end
  end

  // Entry storage: overwrite a coalesced slot or fill the tail slot.
  always_comb begin
    entries_d = entries_q;
    if (coalesce) begin
      entries_d[coalesce_idx].data = st_word;
    end else if (push) begin
      entries_d[tail_q].waddr = st_waddr;
      entries_d[tail_q].data  = st_word;
    end else begin
      entries_d[tail_q] = entries_q[tail_q];
    end
  end

  // Pointer, occupancy and write-latency bookkeeping for the next cycle.
  always_comb begin
    if (pop) begin
      head_d = head_q + PW'(1);
    end else begin
      head_d = head_q;
    end

    if (push) begin
      tail_d = tail_q + PW'(1);
    end else begin
      tail_d = tail_q;
    end

    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end

    if (draining) begin
      if (pop) begin
        lat_cnt_d = LW'(0);
      end else begin
        lat_cnt_d = lat_cnt_q + LW'(1);
      end
    end else begin
      lat_cnt_d = LW'(0);
    end
  end

  // Drain FSM next state: start one cycle after occupancy is registered,
  // keep writing back-to-back while entries remain after the pop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (count_q != CW'(0)) begin
          state_d = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (pop && (count_d == CW'(0))) begin
          state_d = IDLE;
        end else begin
          state_d = WRITE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM outputs and flags, decoded from registered state only.
  always_comb begin
    mem_write_en = (state_q == WRITE);
    empty        = (count_q == CW'(0));
    full         = (count_q == CW'(DEPTH));
    st_ready     = !full;
    if (count_q != CW'(0)) begin
      mem_addr = {entries_q[head_q].waddr, 2'b00};
      for (int b = 0; b < WORD_BYTES; b++) begin
        mem_data_in[b] = entries_q[head_q].data[b];
      end
    end else begin
      mem_addr = 32'h0000_0000;
      for (int b = 0; b < WORD_BYTES; b++) begin
        mem_data_in[b] = 8'h00;
      end
    end
  end

  // Load forwarding from registered entries: a non-draining match wins over
  // the in-flight head; no hit yields an all-zero word.
  always_comb begin
    ld_hit   = 1'b0;
    fwd_word = {(WORD_BYTES * 8){1'b0}};
    if (!ld_valid) begin
      ld_hit = 1'b0;
    end else if (|ld_nd_hit) begin
      ld_hit = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        fwd_word = fwd_word | (entries_q[i].data & {(WORD_BYTES * 8){ld_nd_hit[i]}});
      end
    end else if (ld_head_hit) begin
      ld_hit   = 1'b1;
      fwd_word = entries_q[head_q].data;
    end else begin
      ld_hit = 1'b0;
    end
    for (int b = 0; b < WORD_BYTES; b++) begin
      ld_data[b] = fwd_word[b];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pointer, count and latency counter registers; reset drops all entries.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      head_q    <= {PW{1'b0}};
      tail_q    <= {PW{1'b0}};
      count_q   <= {CW{1'b0}};
      lat_cnt_q <= {LW{1'b0}};
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  // Entry payload storage; contents are meaningless until counted as live.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

endmodule
